// File: rtl/tml_pkg.sv
// Shared types and constants for the triplet margin loss operators.
package tml_pkg;

    typedef enum logic [1:0] {
        LOAD,
        DECIDE,
        EMIT
    } tml_state_e;

    localparam longint unsigned TML_MARGIN = 64'd65536;

    function automatic int tml_acc_w(input int dw, input int dim);
        return 2 * dw + 2 + $clog2(dim);
    endfunction

endpackage

// File: rtl/tml_sqdiff_acc.sv
// Squared-difference accumulator: acc += (x - y)^2, with clear and enable.
module tml_sqdiff_acc
    import tml_pkg::*;
#(
    parameter int DW   = 16,
    parameter int ACCW = 37
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    output logic [ACCW-1:0]      acc_o
);

    logic signed [DW:0]     diff;
    logic signed [2*DW+1:0] prod;
    logic [ACCW-1:0]        acc_q, acc_d;

    assign diff = {x_i[DW-1], x_i} - {y_i[DW-1], y_i};
    assign prod = diff * diff;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_q + {{(ACCW-2*DW-2){1'b0}}, prod};
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/triplet_margin_loss_bwd.sv
// Triplet margin loss backward: buffer one triplet, decide hinge, stream grads.
// Optional loss output enabled by defining TML_LOSS_OUT_EN.
module triplet_margin_loss_bwd
    import tml_pkg::*;
#(
    parameter int              DW     = 16,
    parameter int              DIM    = 8,
    parameter longint unsigned MARGIN = TML_MARGIN,
    localparam int             ACCW   = tml_acc_w(DW, DIM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic signed [DW-1:0] a_in,
    input  logic signed [DW-1:0] p_in,
    input  logic signed [DW-1:0] n_in,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic signed [DW+1:0] grad_a,
    output logic signed [DW+1:0] grad_p,
    output logic signed [DW+1:0] grad_n,
    output logic                 last_out,
    output logic                 active_out
`ifdef TML_LOSS_OUT_EN
    ,
    output logic [ACCW+1:0]      loss_out
`endif
);

    localparam int IW = $clog2(DIM);
    typedef logic [IW-1:0] idx_t;
    localparam idx_t IDX_LAST = idx_t'(DIM - 1);
    localparam logic [ACCW+1:0] MARG = (ACCW+2)'(MARGIN);

    tml_state_e state_q, state_d;
    idx_t       idx_q, idx_d, sel;
    logic       ready_q, in_hs, out_hs;
    logic       acc_en, acc_clr, ld_out;

    logic signed [DW-1:0] a_buf_q [DIM];
    logic signed [DW-1:0] p_buf_q [DIM];
    logic signed [DW-1:0] n_buf_q [DIM];

    logic [ACCW-1:0]      dap, dan;
    logic [ACCW+1:0]      hsum;
    logic                 hinge, act_sel;
    logic signed [DW:0]   d_np, d_pa, d_an;
    logic signed [DW+1:0] ga_d, gp_d, gn_d;

    logic                 valid_q, last_q, active_q;
    logic signed [DW+1:0] ga_q, gp_q, gn_q;

    assign in_hs  = valid_in & ready_q;
    assign out_hs = valid_q & ready_out;

    tml_sqdiff_acc #(.DW(DW), .ACCW(ACCW)) u_dap (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .x_i   (a_in),
        .y_i   (p_in),
        .acc_o (dap)
    );

    tml_sqdiff_acc #(.DW(DW), .ACCW(ACCW)) u_dan (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .x_i   (a_in),
        .y_i   (n_in),
        .acc_o (dan)
    );

    // Two's-complement sum in ACCW+2 bits; strictly positive means active.
    assign hsum  = {2'b00, dap} - {2'b00, dan} + MARG;
    assign hinge = ~hsum[ACCW+1] & (|hsum);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_en  = 1'b0;
        acc_clr = 1'b0;
        ld_out  = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (in_hs) begin
                    acc_en = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = DECIDE;
                    end else begin
                        idx_d = idx_q + idx_t'(1);
                    end
                end
            end
            DECIDE: begin
                ld_out  = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                if (out_hs) begin
                    if (last_q) begin
                        idx_d   = '0;
                        acc_clr = 1'b1;
                        state_d = LOAD;
                    end else begin
                        idx_d  = idx_q + idx_t'(1);
                        ld_out = 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Element feeding the output register on the next load.
    assign sel     = (state_q == EMIT && !last_q) ? idx_q + idx_t'(1) : '0;
    assign act_sel = (state_q == DECIDE) ? hinge : active_q;

    assign d_np = {n_buf_q[sel][DW-1], n_buf_q[sel]}
                - {p_buf_q[sel][DW-1], p_buf_q[sel]};
    assign d_pa = {p_buf_q[sel][DW-1], p_buf_q[sel]}
                - {a_buf_q[sel][DW-1], a_buf_q[sel]};
    assign d_an = {a_buf_q[sel][DW-1], a_buf_q[sel]}
                - {n_buf_q[sel][DW-1], n_buf_q[sel]};

    assign ga_d = act_sel ? {d_np, 1'b0} : '0;
    assign gp_d = act_sel ? {d_pa, 1'b0} : '0;
    assign gn_d = act_sel ? {d_an, 1'b0} : '0;

    always_ff @(posedge clk) begin
        if (in_hs) begin
            a_buf_q[idx_q] <= a_in;
            p_buf_q[idx_q] <= p_in;
            n_buf_q[idx_q] <= n_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            idx_q    <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            active_q <= 1'b0;
            ga_q     <= '0;
            gp_q     <= '0;
            gn_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= (state_d == LOAD);
            if (ld_out) begin
                valid_q  <= 1'b1;
                last_q   <= (sel == IDX_LAST);
                active_q <= act_sel;
                ga_q     <= ga_d;
                gp_q     <= gp_d;
                gn_q     <= gn_d;
            end else if (out_hs) begin
                valid_q  <= 1'b0;
                last_q   <= 1'b0;
                active_q <= 1'b0;
                ga_q     <= '0;
                gp_q     <= '0;
                gn_q     <= '0;
            end
        end
    end

`ifdef TML_LOSS_OUT_EN
    logic [ACCW+1:0] loss_q;

    always_ff @(posedge clk) begin
        if (rst)
            loss_q <= '0;
        else if (state_q == DECIDE)
            loss_q <= hinge ? hsum : '0;
    end

    assign loss_out = loss_q;
`endif

    assign ready_in   = ready_q;
    assign valid_out  = valid_q;
    assign last_out   = last_q;
    assign active_out = active_q;
    assign grad_a     = ga_q;
    assign grad_p     = gp_q;
    assign grad_n     = gn_q;

endmodule

// File: tb/tb_triplet_margin_loss_bwd.sv
// Directed self-checking bench for triplet_margin_loss_bwd at DIM=4.
`timescale 1ns/1ps
module tb_triplet_margin_loss_bwd;

    localparam int DW   = 16;
    localparam int DIM  = 4;
    localparam int ACCW = 2 * DW + 2 + $clog2(DIM);
    localparam int MAXW = 40;

    typedef logic signed [DW-1:0] vec_t [DIM];
    typedef longint ev_t [DIM];

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 valid_in = 1'b0;
    logic                 ready_out = 1'b1;
    logic signed [DW-1:0] a_in = '0;
    logic signed [DW-1:0] p_in = '0;
    logic signed [DW-1:0] n_in = '0;
    logic                 ready_in, valid_out, last_out, active_out;
    logic signed [DW+1:0] grad_a, grad_p, grad_n;
`ifdef TML_LOSS_OUT_EN
    logic [ACCW+1:0]      loss_out;
`endif

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;

    triplet_margin_loss_bwd #(.DW(DW), .DIM(DIM), .MARGIN(65536)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .a_in       (a_in),
        .p_in       (p_in),
        .n_in       (n_in),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .grad_a     (grad_a),
        .grad_p     (grad_p),
        .grad_n     (grad_n),
        .last_out   (last_out),
        .active_out (active_out)
`ifdef TML_LOSS_OUT_EN
        ,
        .loss_out   (loss_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (valid_out && ready_out)
            hs_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input vec_t av, input vec_t pv, input vec_t nv,
                        input bit keep, output int first_wait);
        int w;
        first_wait = 0;
        for (int b = 0; b < DIM; b++) begin
            w = 0;
            valid_in = 1'b1;
            a_in = av[b];
            p_in = pv[b];
            n_in = nv[b];
            while (!ready_in && w < MAXW) begin
                step();
                w++;
            end
            if (b == 0)
                first_wait = w;
            if (!ready_in) begin
                check("send_timeout", 0, 1);
                valid_in = 1'b0;
                return;
            end
            step();
        end
        if (!keep)
            valid_in = 1'b0;
    endtask

    task automatic collect(input string tag, input ev_t ga, input ev_t gp,
                           input ev_t gn, input bit act, input int stall_beat,
                           output int first_wait);
        int w;
        first_wait = 0;
        for (int b = 0; b < DIM; b++) begin
            w = 0;
            while (!valid_out && w < MAXW) begin
                step();
                w++;
            end
            if (b == 0)
                first_wait = w;
            if (!valid_out) begin
                check($sformatf("%s_timeout", tag), 0, 1);
                return;
            end
            check($sformatf("%s_ga%0d", tag, b), grad_a, ga[b]);
            check($sformatf("%s_gp%0d", tag, b), grad_p, gp[b]);
            check($sformatf("%s_gn%0d", tag, b), grad_n, gn[b]);
            check($sformatf("%s_last%0d", tag, b), last_out, (b == DIM - 1));
            check($sformatf("%s_act%0d", tag, b), active_out, act);
            if (b == stall_beat) begin
                ready_out = 1'b0;
                repeat (3) begin
                    step();
                    check($sformatf("%s_hold_v", tag), valid_out, 1);
                    check($sformatf("%s_hold_ga", tag), grad_a, ga[b]);
                    check($sformatf("%s_hold_gp", tag), grad_p, gp[b]);
                    check($sformatf("%s_hold_last", tag), last_out, 0);
                end
                ready_out = 1'b1;
            end
            step();
        end
        check($sformatf("%s_idle", tag), valid_out, 0);
    endtask

    vec_t v256  = '{default: 256};
    vec_t v512  = '{default: 512};
    vec_t v0    = '{default: 0};
    vec_t v128  = '{default: 128};
    vec_t va    = '{256, -256, 512, 0};
    vec_t vp    = '{0, 0, 0, 256};
    vec_t vn    = '{128, 128, 256, -128};
    ev_t  e_m512 = '{default: -512};
    ev_t  e_512  = '{default: 512};
    ev_t  e_0    = '{default: 0};
    ev_t  xa     = '{256, 256, 512, -768};
    ev_t  xp     = '{-512, 512, -1024, 512};
    ev_t  xn     = '{256, -768, 512, 256};

    initial begin
        int wi, wo, h0, gap, wa, wb;

        repeat (3) step();
        check("rst_ready", ready_in, 0);
        check("rst_valid", valid_out, 0);
        check("rst_ga", grad_a, 0);
        check("rst_last", last_out, 0);
        check("rst_active", active_out, 0);
        rst = 1'b0;
        step();
        check("ready_after_rst", ready_in, 1);

        send(v256, v512, v256, 1'b0, wi);
        collect("act", e_m512, e_512, e_0, 1'b1, -1, wo);
        check("act_latency", wo, 1);
`ifdef TML_LOSS_OUT_EN
        check("act_loss", loss_out, 327680);
`endif

        send(v256, v256, v512, 1'b0, wi);
        collect("inact", e_0, e_0, e_0, 1'b0, -1, wo);
        check("inact_latency", wo, 1);
`ifdef TML_LOSS_OUT_EN
        check("inact_loss", loss_out, 0);
`endif

        send(v0, v0, v128, 1'b0, wi);
        collect("edge", e_0, e_0, e_0, 1'b0, -1, wo);
`ifdef TML_LOSS_OUT_EN
        check("edge_loss", loss_out, 0);
`endif

        send(va, vp, vn, 1'b0, wi);
        collect("mix", xa, xp, xn, 1'b1, -1, wo);
`ifdef TML_LOSS_OUT_EN
        check("mix_loss", loss_out, 278528);
`endif

        send(v256, v512, v256, 1'b0, wi);
        h0 = hs_cnt;
        collect("bp", e_m512, e_512, e_0, 1'b1, 1, wo);
        check("bp_hs", hs_cnt - h0, DIM);

        valid_in = 1'b1;
        a_in = 256;
        p_in = 512;
        n_in = 256;
        step();
        step();
        valid_in = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_ready", ready_in, 0);
        check("mid_rst_valid", valid_out, 0);
        rst = 1'b0;
        step();
        send(v0, v0, v128, 1'b0, wi);
        collect("fresh", e_0, e_0, e_0, 1'b0, -1, wo);
        check("fresh_latency", wo, 1);

        fork
            begin
                send(v256, v512, v256, 1'b1, wa);
                send(v256, v256, v512, 1'b0, gap);
            end
            begin
                collect("b2b_a", e_m512, e_512, e_0, 1'b1, -1, wb);
                collect("b2b_b", e_0, e_0, e_0, 1'b0, -1, wb);
            end
        join
        check("b2b_gap", gap, DIM + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
